coin_dispenser: RTL and testbench
=================================

Name: coin_dispenser

Overview:
- Transmitter side of the nickel/dime coin-pulse interface consumed by the vending FSM.
- Takes a cents amount over a valid/ready request and emits a greedy sequence of one-cycle dime/nickel pulses.
- Pulses are separated by idle gaps so a downstream one-coin-per-cycle FSM sees each coin as a distinct event.
- Used for change return and as a stimulus source for the vending FSM.

Parameters:
- AMOUNT_W, 8, width of the request amount in cents.
- GAP_CYCLES, 2, minimum idle cycles after every coin pulse; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  1  request present.
- req_amount  input  AMOUNT_W  amount in cents; sampled on handshake.
- req_ready  output  1  high only in IDLE.
- hold  input  1  mechanism backpressure; stretches GAP.
- nickel  output  1  one-cycle pulse, 5 cents.
- dime  output  1  one-cycle pulse, 10 cents.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a legal request completes.
- err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset: clk and rst as decided above. State goes to IDLE, remaining=0, gap counter=0.
  - Outputs in reset: nickel, dime, done, err and busy are 0; req_ready is 1.
  - No handshake completes while rst is high.
  - rst mid-sequence aborts the request immediately. No further pulses and no done.
- Outputs are Moore, decoded from state only:
  - req_ready = IDLE
  - dime = DIME
  - nickel = NICKEL
  - done = DONE
  - err = ERR
- States: IDLE, DIME, NICKEL, GAP, DONE, ERR.
- IDLE: a handshake (req_valid && req_ready) at edge T captures req_amount into remaining. The next state is chosen from req_amount:
  - amount mod 5 != 0 -> ERR
  - amount >= 10 -> DIME
  - amount == 5 -> NICKEL
  - amount == 0 -> DONE, with no pulses
- DIME: exactly one cycle. remaining -= 10, gap counter loads GAP_CYCLES, go to GAP.
- NICKEL: same as DIME, with remaining -= 5.
- GAP:
  - Counter decrements each cycle while hold=0 and freezes while hold=1.
  - GAP exits only when counter == 1 and hold == 0.
  - On exit, next state from remaining: >=10 -> DIME, ==5 -> NICKEL, ==0 -> DONE.
- DONE and ERR last one cycle, then return to IDLE.
- Arithmetic: remaining is AMOUNT_W wide and never underflows, because subtraction only occurs when remaining >= coin value. The mod-5 check is combinational on the full AMOUNT_W input.
- req_amount changes outside the handshake cycle are ignored. req_valid held high during busy is ignored.
- Latency example, amount 25, GAP_CYCLES=2, accepted at edge 0:
  - DIME at cycle 1, GAP at cycles 2-3
  - DIME at cycle 4, GAP at cycles 5-6
  - NICKEL at cycle 7, GAP at cycles 8-9
  - DONE at cycle 10, IDLE (req_ready=1) at cycle 11
- Maximum amount: 2^AMOUNT_W-1 rounded down to a multiple of 5.
- dime and nickel are never high together, and never high on consecutive cycles.

Optional Feature:
- Macro: COIN_DISPENSER_QUARTER_EN.
- Defined:
  - Adds output quarter (1 bit) and state QUARTER.
  - Greedy order becomes remaining >= 25 -> QUARTER (remaining -= 25), then the dime/nickel rules.
  - QUARTER is followed by GAP like other coins.
- Undefined: no quarter port or state; only dimes and nickels are issued. Example: 25 cents -> dime, dime, nickel.

Decomposition:
- Package coin_pkg holds:
  - COIN_DISPENSER_state enum, 3 bits.
  - Constants NICKEL_CENTS=5, DIME_CENTS=10, QUARTER_CENTS=25.
- Sub-module coin_gap_timer: loadable down-counter with freeze input and an expire flag. The top FSM instantiates it once.

Test Plan:
- rst mid-run, then amount 30, GAP_CYCLES=2 -> dime at cycles 1, 4, 7; done at cycle 10; zero nickels; req_ready low for cycles 1-10.
- amount 5 -> single nickel at cycle 1, done at cycle 4. amount 0 -> done at cycle 1, no pulses.
- amount 17 -> err pulse at cycle 1, no coins, req_ready back at cycle 2. Then amount 15 is accepted normally: dime, nickel, done.
- amount 20 with hold=1 for 5 cycles during the first GAP -> second dime delayed by exactly 5 cycles, done 5 cycles later than nominal.
- Async rst asserted on the cycle after the first dime of amount 40 -> dime/nickel/done stay 0 and the state is IDLE. Released, then amount 10 is accepted -> one dime, done.
- With COIN_DISPENSER_QUARTER_EN, amount 40 -> quarter, dime, nickel. Without the macro, amount 40 -> four dimes. Both checked by a scoreboard summing pulses to 40.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared types and coin values for the coin dispenser.
// COIN_DISPENSER_QUARTER_EN adds the QUARTER state.
package coin_pkg;

  localparam int NICKEL_CENTS  = 5;
  localparam int DIME_CENTS    = 10;
  localparam int QUARTER_CENTS = 25;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIME    = 3'd1,
    NICKEL  = 3'd2,
    GAP     = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
`ifdef COIN_DISPENSER_QUARTER_EN
    ,
    QUARTER = 3'd6
`endif
  } COIN_DISPENSER_state;

endpackage

// File: rtl/coin_gap_timer.sv
// Loadable down-counter that times the idle gap after each coin pulse.
// The counter stops at zero; freeze holds its value.
module coin_gap_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       freeze,
  output logic       expire
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!freeze && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // The gap ends on the cycle the counter reads 1.
  assign expire = (cnt == 4'd1);

endmodule

// File: rtl/coin_dispenser.sv
// Coin dispenser: turns a cents request into greedy one-cycle coin pulses separated by gaps.
// Define COIN_DISPENSER_QUARTER_EN to add quarter pulses.
module coin_dispenser
  import coin_pkg::*;
#(
  parameter int AMOUNT_W   = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [AMOUNT_W-1:0] req_amount,
  output logic                req_ready,
  input  logic                hold,
  output logic                nickel,
  output logic                dime,
`ifdef COIN_DISPENSER_QUARTER_EN
  output logic                quarter,
`endif
  output logic                busy,
  output logic                done,
  output logic                err,
  output COIN_DISPENSER_state dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and req_ready
  // are both high; req_ready is high only in IDLE, so that edge captures req_amount.

  COIN_DISPENSER_state state, next_state;
  logic [AMOUNT_W-1:0] remaining;
  logic                coin_st;
  logic                gap_expire;

  // Greedy choice of the next coin; a zero balance means the request is complete.
  function automatic COIN_DISPENSER_state pick_coin(input logic [AMOUNT_W-1:0] r);
`ifdef COIN_DISPENSER_QUARTER_EN
    if (r >= AMOUNT_W'(QUARTER_CENTS)) return QUARTER;
`endif
    if (r >= AMOUNT_W'(DIME_CENTS)) return DIME;
    if (r >= AMOUNT_W'(NICKEL_CENTS)) return NICKEL;
    return DONE;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if ((req_amount % AMOUNT_W'(NICKEL_CENTS)) != '0) begin
            next_state = ERR;
          end else begin
            next_state = pick_coin(req_amount);
          end
        end
      end
      DIME, NICKEL: next_state = GAP;
`ifdef COIN_DISPENSER_QUARTER_EN
      QUARTER:      next_state = GAP;
`endif
      GAP: begin
        if (gap_expire && !hold) begin
          next_state = pick_coin(remaining);
        end
      end
      DONE, ERR:    next_state = IDLE;
      default:      next_state = IDLE;
    endcase
  end

  // Subtraction happens only in a coin state, which is entered only when remaining covers the coin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
    end else begin
      case (state)
        IDLE:    if (req_valid) remaining <= req_amount;
        DIME:    remaining <= remaining - AMOUNT_W'(DIME_CENTS);
        NICKEL:  remaining <= remaining - AMOUNT_W'(NICKEL_CENTS);
`ifdef COIN_DISPENSER_QUARTER_EN
        QUARTER: remaining <= remaining - AMOUNT_W'(QUARTER_CENTS);
`endif
        default: remaining <= remaining;
      endcase
    end
  end

`ifdef COIN_DISPENSER_QUARTER_EN
  assign coin_st = (state == DIME) || (state == NICKEL) || (state == QUARTER);
`else
  assign coin_st = (state == DIME) || (state == NICKEL);
`endif

  coin_gap_timer u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (coin_st),
    .load_val (4'(GAP_CYCLES)),
    .freeze   (hold),
    .expire   (gap_expire)
  );

  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    dime      = (state == DIME);
    nickel    = (state == NICKEL);
`ifdef COIN_DISPENSER_QUARTER_EN
    quarter   = (state == QUARTER);
`endif
    done      = (state == DONE);
    err       = (state == ERR);
    dbg_state = state;
  end

endmodule

// File: tb/tb_coin_dispenser.sv
// Bench for coin_dispenser: table of requests, greedy reference model feeding an expected-event queue.
// Honours COIN_DISPENSER_QUARTER_EN the same way the design does.
module tb_coin_dispenser;
  import coin_pkg::*;

  localparam int AW    = 8;
  localparam int GAP_N = 2;
  localparam logic [7:0] CODE_DONE = 8'hD0;
  localparam logic [7:0] CODE_ERR  = 8'hE0;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [AW-1:0] req_amount;
  logic          req_ready;
  logic          hold;
  logic          nickel;
  logic          dime;
`ifdef COIN_DISPENSER_QUARTER_EN
  logic          quarter;
`endif
  logic          busy;
  logic          done;
  logic          err;
  COIN_DISPENSER_state dbg_state;

  coin_dispenser #(.AMOUNT_W(AW), .GAP_CYCLES(GAP_N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_amount (req_amount),
    .req_ready  (req_ready),
    .hold       (hold),
    .nickel     (nickel),
    .dime       (dime),
`ifdef COIN_DISPENSER_QUARTER_EN
    .quarter    (quarter),
`endif
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: each entry is {cycle, event code}
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cents_sum;
  int last_evt_c;

  typedef struct {
    int amount;
    int hold_len;
    bit keep_valid;
    bit exp_err;
    int exp_end;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: greedy coins, one pulse then GAP_N idle cycles, hold stretches the first gap.
  task automatic push_expect(input int amount, input int hold_len, output int end_cyc);
    int rem, cyc, coin;
    bit first;
    if (amount % 5 != 0) begin
      exp_q.push_back({8'd1, CODE_ERR});
      end_cyc = 1;
    end else begin
      rem = amount;
      cyc = 1;
      first = 1'b1;
      while (rem > 0) begin
`ifdef COIN_DISPENSER_QUARTER_EN
        if (rem >= 25) coin = 25;
        else if (rem >= 10) coin = 10;
        else coin = 5;
`else
        if (rem >= 10) coin = 10;
        else coin = 5;
`endif
        exp_q.push_back({8'(cyc), 8'(coin)});
        rem -= coin;
        cyc += 1 + GAP_N + (first ? hold_len : 0);
        first = 1'b0;
      end
      exp_q.push_back({8'(cyc), CODE_DONE});
      end_cyc = cyc;
    end
  endtask

  task automatic monitor(input int c, input int end_cyc);
    int n;
    logic [7:0] code;
    logic [15:0] e;
    chk("busy", busy, (c <= end_cyc));
    chk("req_ready", req_ready, (c > end_cyc));
    n = 0;
    code = 8'h00;
    if (dime)   begin n++; code = 8'd10; cents_sum += 10; end
    if (nickel) begin n++; code = 8'd5;  cents_sum += 5;  end
`ifdef COIN_DISPENSER_QUARTER_EN
    if (quarter) begin n++; code = 8'd25; cents_sum += 25; end
`endif
    if (done)   begin n++; code = CODE_DONE; end
    if (err)    begin n++; code = CODE_ERR;  end
    if (n > 1) chk("one_hot_outputs", n, 1);
    if (n == 1) begin
      last_evt_c = c;
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {8'(c), code}, 16'h0);
      end else begin
        e = exp_q.pop_front();
        chk("event_cycle_code", {8'(c), code}, e);
      end
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) chk("ready_timeout", req_ready, 1);
  endtask

  // driver: one request, monitored until one cycle past its last event
  task automatic run_req(input int amount, input int hold_len, input bit keep);
    int end_cyc;
    wait_ready();
    push_expect(amount, hold_len, end_cyc);
    cents_sum = 0;
    last_evt_c = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_amount = AW'(amount);
    @(posedge clk);
    #1;
    req_valid  = keep;
    req_amount = AW'($urandom_range(0, 255));
    for (int c = 1; c <= end_cyc + 1; c++) begin
      @(negedge clk);
      monitor(c, end_cyc);
      hold = (c >= 2) && (c < 2 + hold_len);
      req_valid  = keep && (c < end_cyc);
      req_amount = AW'($urandom_range(0, 255));
    end
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    chk("cents_sum", cents_sum, (amount % 5 != 0) ? 0 : amount);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_amount = '0;
    hold = 1'b0;

`ifdef COIN_DISPENSER_QUARTER_EN
    vecs[0]  = '{30, 0, 1'b0, 1'b0, 7};
    vecs[6]  = '{25, 0, 1'b1, 1'b0, 4};
    vecs[7]  = '{40, 0, 1'b0, 1'b0, 10};
    vecs[8]  = '{255, 0, 1'b0, 1'b0, 34};
`else
    vecs[0]  = '{30, 0, 1'b0, 1'b0, 10};
    vecs[6]  = '{25, 0, 1'b1, 1'b0, 10};
    vecs[7]  = '{40, 0, 1'b0, 1'b0, 13};
    vecs[8]  = '{255, 0, 1'b0, 1'b0, 79};
`endif
    vecs[1]  = '{5, 0, 1'b0, 1'b0, 4};
    vecs[2]  = '{0, 0, 1'b0, 1'b0, 1};
    vecs[3]  = '{17, 0, 1'b0, 1'b1, 1};
    vecs[4]  = '{15, 0, 1'b0, 1'b0, 7};
    vecs[5]  = '{20, 5, 1'b0, 1'b0, 12};
    vecs[9]  = '{7, 0, 1'b0, 1'b1, 1};
    vecs[10] = '{254, 0, 1'b0, 1'b1, 1};
    vecs[11] = '{1, 0, 1'b0, 1'b1, 1};

    // reset state, with a request offered that must not be taken
    req_valid = 1'b1;
    req_amount = AW'(10);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_coins", {dime, nickel, done, err}, 4'b0);
    chk("rst_state", dbg_state, IDLE);
    req_valid = 1'b0;
    rst = 1'b0;

    // async reset right after the first dime of a 40-cent request
    @(negedge clk);
    req_valid = 1'b1;
    req_amount = AW'(40);
    exp_q.push_back({8'd1, 8'd10});
    cents_sum = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    monitor(1, 100);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_state", dbg_state, IDLE);
    chk("abort_ready", req_ready, 1);
    req_valid = 1'b1;
    req_amount = AW'(10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_quiet", {dime, nickel, done, err, busy}, 5'b0);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    chk("abort_queue", exp_q.size(), 0);
    exp_q.delete();
    run_req(10, 0, 1'b0);
    chk("post_abort_sum", cents_sum, 10);

    // table-driven requests
    foreach (vecs[i]) begin
      run_req(vecs[i].amount, vecs[i].hold_len, vecs[i].keep_valid);
      chk($sformatf("end_cycle_amt%0d", vecs[i].amount), last_evt_c, vecs[i].exp_end);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
